// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM bus controller.
package bootram_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned DEF_ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: bridges the PicoRV32 native bus and a byte-stream loader
// onto four 8-bit BSRAM lanes, covering the one-cycle synchronous read latency.
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned LD_PTR_W = ADDR_W + 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic                 mem_sel,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  input  logic                 ld_start,
  input  logic                 ld_end,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic                 ld_busy,
  output logic                 ld_ovf,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout,
  output logic [3:0]           ram_ce,
  output logic                 ram_wre,
  output logic                 ram_oce,
  output logic                 ram_reset
);

  state_e                state_q, state_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  rd_q, rd_d;
  logic                  ld_acc_q, ld_acc_d;
  logic                  ld_busy_q, ld_busy_d;
  logic                  ld_ovf_q, ld_ovf_d;
  logic [LD_PTR_W-1:0]   ptr_q, ptr_d;
  logic [LD_PTR_W:0]     ptr_inc;
  logic [ADDR_W-1:0]     ram_ad_q, ram_ad_d;
  logic [31:0]           ram_din_q, ram_din_d;
  logic [3:0]            ram_ce_q, ram_ce_d;
  logic                  ram_wre_q, ram_wre_d;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    rd_d        = rd_q;
    ld_acc_d    = ld_acc_q;
    ld_busy_d   = ld_busy_q;
    ld_ovf_d    = ld_ovf_q;
    ptr_d       = ptr_q;
    ram_ad_d    = ram_ad_q;
    ram_din_d   = ram_din_q;
    ram_ce_d    = '0;
    ram_wre_d   = 1'b0;
    ptr_inc     = {1'b0, ptr_q} + {{LD_PTR_W{1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (ld_busy_q) begin
          if (ld_valid) begin
            state_d   = ACCESS;
            ld_acc_d  = 1'b1;
            rd_d      = 1'b0;
            ram_ad_d  = ptr_q[LD_PTR_W-1:2];
            ram_din_d = {LANES{ld_data}};
            ram_ce_d  = 4'b0001 << ptr_q[1:0];
            ram_wre_d = 1'b1;
          end
        end else if (mem_valid && mem_sel) begin
          state_d  = ACCESS;
          ld_acc_d = 1'b0;
          rd_d     = (mem_wstrb == 4'b0000);
          ram_ad_d = mem_addr[ADDR_W+1:2];
          if (mem_wstrb == 4'b0000) begin
            ram_ce_d = 4'hF;
          end else begin
            ram_ce_d  = mem_wstrb;
            ram_wre_d = 1'b1;
            ram_din_d = mem_wdata;
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        mem_ready_d = ~ld_acc_q;
        if (ld_acc_q) begin
          ptr_d = ptr_inc[LD_PTR_W-1:0];
          if (ptr_inc[LD_PTR_W]) ld_ovf_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ld_start overrides both ld_end and any pointer advance from an in-flight byte
    if (ld_start) begin
      ld_busy_d = 1'b1;
      ptr_d     = '0;
      ld_ovf_d  = 1'b0;
    end else if (ld_end) begin
      ld_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_ready_q <= 1'b0;
      rd_q        <= 1'b0;
      ld_acc_q    <= 1'b0;
      ld_busy_q   <= 1'b0;
      ld_ovf_q    <= 1'b0;
      ptr_q       <= '0;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
      ram_ce_q    <= '0;
      ram_wre_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      rd_q        <= rd_d;
      ld_acc_q    <= ld_acc_d;
      ld_busy_q   <= ld_busy_d;
      ld_ovf_q    <= ld_ovf_d;
      ptr_q       <= ptr_d;
      ram_ad_q    <= ram_ad_d;
      ram_din_q   <= ram_din_d;
      ram_ce_q    <= ram_ce_d;
      ram_wre_q   <= ram_wre_d;
    end
  end

  // Lane output is already registered inside the BSRAM, so read data is muxed straight through
  assign mem_ready = mem_ready_q;
  assign mem_rdata = (mem_ready_q && rd_q) ? ram_dout : '0;
  assign ld_ready  = (state_q == IDLE) && ld_busy_q;
  assign ld_busy   = ld_busy_q;
  assign ld_ovf    = ld_ovf_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;
  assign ram_ce    = ram_ce_q;
  assign ram_wre   = ram_wre_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = ~resetn;

endmodule
